pm_sequencer: RTL and testbench
===============================

PM_SEQUENCER -- requirements
Module: pm_sequencer

Interface
REQ-001 Parameter PM_W, default 5: width of the path-metric bus driven to the path-metric node.
REQ-002 Parameter NODE_W, default 8: width of the node result buses data0..data3.
REQ-003 Parameter INIT_BIAS, default 31: initial metric of states 1..3 at frame start; saturated to 2^PM_W-1.
REQ-004 Parameter TIMEOUT, default 15: maximum number of WAIT cycles before the node is declared hung.
REQ-005 One clock; reset is asynchronous and active-low. Clock port clk; reset port rst, active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 sym_valid  in  1  branch-metric symbol offered.
REQ-009 sym_ready  out  1  symbol accepted when sym_valid and sym_ready are both high.
REQ-010 sym_bm  in  16  packed {bm0_1,bm0_2,bm1_1,bm1_2,bm2_1,bm2_2,bm3_1,bm3_2}, 2 bits each.
REQ-011 sym_last  in  1  the symbol closes the frame.
REQ-012 node_st  out  1  one-cycle start pulse to the node.
REQ-013 node_bm  out  16  latched sym_bm, held stable from accept until the next accept.
REQ-014 pre_metric0..3  out  PM_W each  current normalised path metrics to the node.
REQ-015 node_done  in  1  node result valid.
REQ-016 node_data0..3  in  NODE_W each  new raw path metrics from the node.
REQ-017 best_valid  out  1  one-cycle pulse: frame result valid.
REQ-018 best_state  out  2  argmin of the final metrics.
REQ-019 frame_len  out  8  number of symbols in the reported frame.
REQ-020 err  out  1  sticky timeout flag; cleared only by rst.

Function
REQ-021 The FSM shall have the states IDLE, LAUNCH, WAIT, NORM and REPORT.
REQ-022 In IDLE, sym_ready=1; in every other state, sym_ready=0.
REQ-023 On accept in IDLE: latch sym_bm into node_bm, latch sym_last, increment sym_cnt (saturating at 255), and go to LAUNCH.
REQ-024 In LAUNCH, node_st=1 for exactly that cycle, then go to WAIT; node_st=0 in all other states.
REQ-025 In WAIT, node_done=1 shall capture node_data0..3 into the raw registers and go to NORM; node_done in any other state shall be ignored.
REQ-026 In WAIT, the wait counter shall increment each cycle; when TIMEOUT cycles pass without node_done, set err, reinitialise the metrics and sym_cnt, and go to IDLE.
REQ-027 In NORM: min = smallest raw value; pm_i = raw_i - min, saturated to 2^PM_W-1; result registered into pre_metric0..3 at the end of NORM.
REQ-028 NORM shall go to REPORT if the latched sym_last is 1, else to IDLE.
REQ-029 In REPORT: best_state = index of the smallest pm, lowest index on a tie; frame_len = sym_cnt; best_valid=1 for one cycle.
REQ-030 REPORT shall reinitialise pre_metric0=0 and pre_metric1..3=INIT_BIAS, clear sym_cnt, and go to IDLE.
REQ-031 best_state and frame_len shall hold their values until the next REPORT.
REQ-032 Minimum symbol period: accept(T), LAUNCH(T+1), WAIT(T+2..), NORM(done+1), IDLE again at done+2.
REQ-033 sym_valid held high outside IDLE shall not cause a second accept.

Reset
REQ-034 While rst=0, the block shall hold: state=IDLE, sym_ready=1, node_st=0, node_bm=0, pre_metric0=0, pre_metric1..3=INIT_BIAS, raw registers=0, sym_cnt=0, best_valid=0, best_state=0, frame_len=0, err=0.
REQ-035 Reset asserted in any state, including mid-WAIT, shall abort the operation; node_done arriving after reset release shall be ignored.

Structure
REQ-036 Package vit_pkg shall hold PM_W, NODE_W, N_STATES=4, INIT_BIAS, TIMEOUT and the FSM state type.
REQ-037 Sub-module pm_min4 shall compute the combinational min and argmin (lowest index on a tie) of four values; NORM and REPORT shall each use one instance.

Verification
REQ-038 After reset, sym_bm=16'h1111 and node returns 1,2,1,2 -> node_st pulses once; pre_metric becomes 0,1,0,1; sym_ready returns at done+2.
REQ-039 Node returns 40,3,3,50 -> pre_metric becomes 31,0,0,31 (saturation).
REQ-040 Three symbols, last with sym_last=1, and node returns 5,2,2,9 on the last -> best_valid pulses once with best_state=1 and frame_len=3; metrics reinitialise to 0,31,31,31.
REQ-041 node_done withheld for 16 WAIT cycles -> err=1 and stays 1; FSM in IDLE; metrics reinitialised; a later node_done is ignored.
REQ-042 sym_valid held high throughout WAIT -> exactly one accept per symbol; node_bm unchanged until the next IDLE accept.
REQ-043 rst pulsed low during WAIT -> all outputs take their REQ-034 values; a node_done arriving after reset release produces no metric update.

Source files
------------

// File: rtl/vit_pkg.sv
// Shared widths, constants and FSM state encoding for the Viterbi path-metric sequencer.
package vit_pkg;
  localparam int PM_W      = 5;
  localparam int NODE_W    = 8;
  localparam int N_STATES  = 4;
  localparam int INIT_BIAS = 31;
  localparam int TIMEOUT   = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_NORM,
    ST_REPORT
  } state_t;
endpackage

// File: rtl/pm_min4.sv
// Combinational minimum and argmin of four values; the lowest index wins a tie.
module pm_min4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  output logic [W-1:0] min_val,
  output logic [1:0]   min_idx
);
  // Strict less-than keeps the earlier index when values are equal.
  always_comb begin
    min_val = a0;
    min_idx = 2'd0;
    if (a1 < min_val) begin
      min_val = a1;
      min_idx = 2'd1;
    end
    if (a2 < min_val) begin
      min_val = a2;
      min_idx = 2'd2;
    end
    if (a3 < min_val) begin
      min_val = a3;
      min_idx = 2'd3;
    end
  end
endmodule

// File: rtl/pm_sequencer.sv
// Sequences branch-metric symbols through an external path-metric node, normalises
// the returned metrics and reports the best final state at the end of each frame.
module pm_sequencer
  import vit_pkg::*;
#(
  parameter int PM_W      = vit_pkg::PM_W,
  parameter int NODE_W    = vit_pkg::NODE_W,
  parameter int INIT_BIAS = vit_pkg::INIT_BIAS,
  parameter int TIMEOUT   = vit_pkg::TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic [15:0]       sym_bm,
  input  logic              sym_last,
  output logic              node_st,
  output logic [15:0]       node_bm,
  output logic [PM_W-1:0]   pre_metric0,
  output logic [PM_W-1:0]   pre_metric1,
  output logic [PM_W-1:0]   pre_metric2,
  output logic [PM_W-1:0]   pre_metric3,
  input  logic              node_done,
  input  logic [NODE_W-1:0] node_data0,
  input  logic [NODE_W-1:0] node_data1,
  input  logic [NODE_W-1:0] node_data2,
  input  logic [NODE_W-1:0] node_data3,
  output logic              best_valid,
  output logic [1:0]        best_state,
  output logic [7:0]        frame_len,
  output logic              err
);
  localparam int PM_MAX = (1 << PM_W) - 1;
  localparam logic [PM_W-1:0] BIAS = PM_W'((INIT_BIAS > PM_MAX) ? PM_MAX : INIT_BIAS);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t state, state_nxt;
  logic [NODE_W-1:0] raw [N_STATES];
  logic [PM_W-1:0]   pm  [N_STATES];
  logic [WC_W-1:0]   wait_cnt;
  logic [7:0]        sym_cnt;
  logic              last_q;
  logic              accept;
  logic              timeout;
  logic [NODE_W-1:0] norm_min;
  logic [1:0]        norm_idx;
  logic [PM_W-1:0]   rep_min;
  logic [1:0]        rep_idx;
  logic              unused_min;

  function automatic logic [PM_W-1:0] sat_pm(input logic [NODE_W-1:0] v);
    if (int'(v) > PM_MAX) return PM_W'(PM_MAX);
    return PM_W'(v);
  endfunction

  pm_min4 #(.W(NODE_W)) u_norm_min (
    .a0(raw[0]), .a1(raw[1]), .a2(raw[2]), .a3(raw[3]),
    .min_val(norm_min), .min_idx(norm_idx)
  );

  pm_min4 #(.W(PM_W)) u_rep_min (
    .a0(pm[0]), .a1(pm[1]), .a2(pm[2]), .a3(pm[3]),
    .min_val(rep_min), .min_idx(rep_idx)
  );

  assign unused_min = ^{norm_idx, rep_min};

  assign accept  = (state == ST_IDLE) && sym_valid;
  // The node may still answer in the cycle the counter reaches TIMEOUT; done wins.
  assign timeout = (state == ST_WAIT) && !node_done && (wait_cnt == WC_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sym_valid) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (node_done)    state_nxt = ST_NORM;
        else if (timeout) state_nxt = ST_IDLE;
      end
      ST_NORM:   state_nxt = last_q ? ST_REPORT : ST_IDLE;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sym_ready = (state == ST_IDLE);
    node_st   = (state == ST_LAUNCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      node_bm    <= '0;
      last_q     <= 1'b0;
      sym_cnt    <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      best_valid <= 1'b0;
      best_state <= '0;
      frame_len  <= '0;
      for (int i = 0; i < N_STATES; i++) begin
        raw[i] <= '0;
        pm[i]  <= (i == 0) ? '0 : BIAS;
      end
    end else begin
      best_valid <= (state == ST_REPORT);
      if (accept) begin
        node_bm <= sym_bm;
        last_q  <= sym_last;
        if (sym_cnt != 8'hFF) sym_cnt <= sym_cnt + 8'd1;
      end
      if (state == ST_LAUNCH) wait_cnt <= '0;
      if (state == ST_WAIT) begin
        if (node_done) begin
          raw[0] <= node_data0;
          raw[1] <= node_data1;
          raw[2] <= node_data2;
          raw[3] <= node_data3;
        end else if (timeout) begin
          err     <= 1'b1;
          sym_cnt <= '0;
          for (int i = 0; i < N_STATES; i++) pm[i] <= (i == 0) ? '0 : BIAS;
        end else begin
          wait_cnt <= wait_cnt + WC_W'(1);
        end
      end
      if (state == ST_NORM) begin
        for (int i = 0; i < N_STATES; i++) pm[i] <= sat_pm(raw[i] - norm_min);
      end
      if (state == ST_REPORT) begin
        best_state <= rep_idx;
        frame_len  <= sym_cnt;
        sym_cnt    <= '0;
        for (int i = 0; i < N_STATES; i++) pm[i] <= (i == 0) ? '0 : BIAS;
      end
    end
  end

  assign pre_metric0 = pm[0];
  assign pre_metric1 = pm[1];
  assign pre_metric2 = pm[2];
  assign pre_metric3 = pm[3];
endmodule

// File: tb/tb_pm_sequencer.sv
// Directed bench for pm_sequencer with a queue-based scoreboard of expected metrics and frame reports.
module tb_pm_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        sym_valid;
  logic        sym_ready;
  logic [15:0] sym_bm;
  logic        sym_last;
  logic        node_st;
  logic [15:0] node_bm;
  logic [4:0]  pre_metric0, pre_metric1, pre_metric2, pre_metric3;
  logic        node_done;
  logic [7:0]  node_data0, node_data1, node_data2, node_data3;
  logic        best_valid;
  logic [1:0]  best_state;
  logic [7:0]  frame_len;
  logic        err;

  localparam logic [19:0] INIT_PM = {5'd31, 5'd31, 5'd31, 5'd0};

  int n_vec = 0;
  int n_miss = 0;
  int n_acc = 0;
  int exp_cnt = 0;
  logic [19:0] pm_q [$];
  logic [9:0]  rpt_q [$];

  pm_sequencer dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_bm(sym_bm), .sym_last(sym_last), .node_st(node_st), .node_bm(node_bm),
    .pre_metric0(pre_metric0), .pre_metric1(pre_metric1),
    .pre_metric2(pre_metric2), .pre_metric3(pre_metric3),
    .node_done(node_done), .node_data0(node_data0), .node_data1(node_data1),
    .node_data2(node_data2), .node_data3(node_data3),
    .best_valid(best_valid), .best_state(best_state), .frame_len(frame_len), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && sym_valid && sym_ready) n_acc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] get_pm();
    return {pre_metric3, pre_metric2, pre_metric1, pre_metric0};
  endfunction

  function automatic logic [19:0] norm(input logic [7:0] d0, d1, d2, d3);
    logic [7:0] d [4];
    logic [7:0] m;
    logic [19:0] r;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    m = d0;
    for (int i = 1; i < 4; i++) if (d[i] < m) m = d[i];
    r = '0;
    for (int i = 0; i < 4; i++) r[i*5 +: 5] = ((d[i] - m) > 8'd31) ? 5'd31 : 5'(d[i] - m);
    return r;
  endfunction

  function automatic logic [1:0] argmin(input logic [19:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 1; i < 4; i++) if (p[i*5 +: 5] < p[idx*5 +: 5]) idx = 2'(i);
    return idx;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, sym_ready, 1);
    chk({tag, "_node_st"}, node_st, 0);
    chk({tag, "_node_bm"}, node_bm, 0);
    chk({tag, "_pm"}, get_pm(), INIT_PM);
    chk({tag, "_best_valid"}, best_valid, 0);
    chk({tag, "_best_state"}, best_state, 0);
    chk({tag, "_frame_len"}, frame_len, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!sym_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_accept", sym_ready, 1);
  endtask

  task automatic send_sym(input logic [15:0] bm, input logic last,
                          input logic [7:0] d0, d1, d2, d3, input int dly, input bit hold);
    int acc0;
    logic [19:0] e;
    logic [9:0] r;
    wait_ready();
    acc0 = n_acc;
    sym_valid = 1'b1; sym_bm = bm; sym_last = last;
    @(negedge clk);
    if (!hold) sym_valid = 1'b0;
    if (exp_cnt < 255) exp_cnt++;
    chk("node_st_launch", node_st, 1);
    chk("node_bm_latched", node_bm, bm);
    chk("ready_launch", sym_ready, 0);
    @(negedge clk);
    chk("node_st_wait", node_st, 0);
    sym_bm = ~bm;
    repeat (dly) @(negedge clk);
    chk("node_bm_held", node_bm, bm);
    chk("ready_wait", sym_ready, 0);
    node_done = 1'b1;
    node_data0 = d0; node_data1 = d1; node_data2 = d2; node_data3 = d3;
    e = norm(d0, d1, d2, d3);
    pm_q.push_back(e);
    if (last) rpt_q.push_back({argmin(e), 8'(exp_cnt)});
    @(negedge clk);
    node_done = 1'b0;
    sym_valid = 1'b0;
    chk("accept_once", n_acc - acc0, 1);
    chk("ready_norm", sym_ready, 0);
    @(negedge clk);
    chk("pre_metric", get_pm(), pm_q.pop_front());
    chk("ready_done_plus2", sym_ready, {31'd0, !last});
    if (last) begin
      chk("best_valid_early", best_valid, 0);
      @(negedge clk);
      r = rpt_q.pop_front();
      exp_cnt = 0;
      chk("best_valid", best_valid, 1);
      chk("best_state", best_state, r[9:8]);
      chk("frame_len", frame_len, r[7:0]);
      chk("pm_reinit_report", get_pm(), INIT_PM);
      @(negedge clk);
      chk("best_valid_pulse", best_valid, 0);
      chk("best_state_hold", best_state, r[9:8]);
      chk("frame_len_hold", frame_len, r[7:0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    sym_valid = 1'b0; sym_bm = '0; sym_last = 1'b0;
    node_done = 1'b0;
    node_data0 = '0; node_data1 = '0; node_data2 = '0; node_data3 = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_release");

    // Basic symbol and saturation with the node answering in the last allowed WAIT cycle.
    send_sym(16'h1111, 1'b0, 8'd1, 8'd2, 8'd1, 8'd2, 0, 1'b0);
    send_sym(16'h2468, 1'b0, 8'd40, 8'd3, 8'd3, 8'd50, 15, 1'b0);
    chk("no_err_at_limit", err, 0);

    // sym_valid held high across the whole symbol.
    send_sym(16'hA5C3, 1'b0, 8'd7, 8'd9, 8'd7, 8'd8, 4, 1'b1);

    // Node hangs: 16 WAIT cycles without done.
    wait_ready();
    sym_valid = 1'b1; sym_bm = 16'h2222; sym_last = 1'b0;
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("err_before_timeout", err, 0);
    chk("ready_before_timeout", sym_ready, 0);
    @(negedge clk);
    exp_cnt = 0;
    chk("err_timeout", err, 1);
    chk("ready_after_timeout", sym_ready, 1);
    chk("pm_reinit_timeout", get_pm(), INIT_PM);
    node_done = 1'b1;
    node_data0 = 8'd9; node_data1 = 8'd0; node_data2 = 8'd9; node_data3 = 8'd0;
    @(negedge clk);
    node_done = 1'b0;
    chk("late_done_ready", sym_ready, 1);
    chk("late_done_node_st", node_st, 0);
    repeat (3) @(negedge clk);
    chk("late_done_pm", get_pm(), INIT_PM);
    chk("err_sticky", err, 1);

    // Three-symbol frame with a tie in the final metrics.
    send_sym(16'h0123, 1'b0, 8'd4, 8'd6, 8'd4, 8'd8, 0, 1'b0);
    send_sym(16'h4567, 1'b0, 8'd10, 8'd3, 8'd12, 8'd3, 2, 1'b0);
    send_sym(16'h89AB, 1'b1, 8'd5, 8'd2, 8'd2, 8'd9, 1, 1'b0);
    chk("err_still_set", err, 1);

    // Reset pulsed mid-WAIT, then a stray done after release.
    wait_ready();
    sym_valid = 1'b1; sym_bm = 16'hBEEF; sym_last = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    exp_cnt = 0;
    check_reset_vals("rst_mid_wait");
    @(negedge clk);
    rst = 1'b1;
    node_done = 1'b1;
    node_data0 = 8'd9; node_data1 = 8'd0; node_data2 = 8'd9; node_data3 = 8'd0;
    @(negedge clk);
    node_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("post_rst_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
